dbg_commit_queue: RTL

//  Commit-side buffer between the writeback stage and the debug/difftest DPI block.

---
 rtl/dbg_commit_pkg.sv | 31 +++
 rtl/dbg_commit_fifo.sv | 63 ++++++
 rtl/dbg_commit_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dbg_commit_pkg.sv
// Shared types for the debug commit queue: the retired-instruction record
// and the halt FSM states.
package dbg_commit_pkg;

    // Register addresses are stored already zero-extended to 32 bits, so the
    // record layout does not depend on GPR_AW/CSR_AW.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        brk;
        logic        ivd;
        logic        gpr_wen;
        logic [31:0] gpr_waddr;
        logic [31:0] gpr_wdata;
        logic        csr_wen;
        logic [31:0] csr_waddr;
        logic [31:0] csr_wdata;
    } commit_rec_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // A record halts the core if it is an ebreak or an invalid instruction.
    function automatic logic is_halting(input commit_rec_t r);
        return r.brk | r.ivd;
    endfunction

endpackage

// File: rtl/dbg_commit_fifo.sv
// Generic DEPTH-entry FIFO of commit records. Pointers wrap naturally
// (DEPTH must be a power of two); count is one bit wider than the pointers.
module dbg_commit_fifo
    import dbg_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  commit_rec_t                wdata_i,
    output commit_rec_t                rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    commit_rec_t       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflow/underflow are blocked here as well as by the caller.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dbg_commit_queue.sv
// Commit-side buffer between writeback and the difftest block. Records are
// queued and replayed one per cycle as a registered done pulse. A brk/ivd
// record stops intake; once it is emitted the block parks in HALTED.
// Optional build macro DBG_COMMIT_CNT_EN adds instret/cycles counters.
module dbg_commit_queue
    import dbg_commit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int GPR_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic              in_brk,
    input  logic              in_ivd,
    input  logic              in_gpr_wen,
    input  logic [GPR_AW-1:0] in_gpr_waddr,
    input  logic [31:0]       in_gpr_wdata,
    input  logic              in_csr_wen,
    input  logic [CSR_AW-1:0] in_csr_waddr,
    input  logic [31:0]       in_csr_wdata,
    output logic              done,
    output logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              brk,
    output logic              ivd,
    output logic              gpr_wen,
    output logic [31:0]       gpr_waddr,
    output logic [31:0]       gpr_wdata,
    output logic              csr_wen,
    output logic [31:0]       csr_waddr,
    output logic [31:0]       csr_wdata,
    output logic              halted
`ifdef DBG_COMMIT_CNT_EN
    ,
    output logic [63:0]       instret,
    output logic [63:0]       cycles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t      state_q, state_d;
    commit_rec_t in_rec, head_rec, out_q;
    logic        done_q;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign in_rec = '{
        pc:        in_pc,
        inst:      in_inst,
        brk:       in_brk,
        ivd:       in_ivd,
        gpr_wen:   in_gpr_wen,
        gpr_waddr: 32'(in_gpr_waddr),
        gpr_wdata: in_gpr_wdata,
        csr_wen:   in_csr_wen,
        csr_waddr: 32'(in_csr_waddr),
        csr_wdata: in_csr_wdata
    };

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = (state_q == RUN) && !fifo_full;
    assign push     = in_valid && in_ready;
    // Drain every cycle the queue is non-empty; no bypass from input.
    assign pop      = !fifo_empty;

    dbg_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Full flag and occupancy must always agree.
    always_comb begin
        assert (reset || (fifo_full == (fifo_count == CW'(DEPTH))));
    end

    // Output register: head is registered and flagged with a one-cycle done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= pop;
            if (pop) out_q <= head_rec;
        end
    end

    // Halt FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Halt FSM next state: stop intake on a halting push, park once it is emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (push && is_halting(in_rec))      state_d = DRAIN;
            DRAIN:   if (done_q && is_halting(out_q))     state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Flags and write enables are qualified by done; data fields hold.
    assign done      = done_q;
    assign pc        = out_q.pc;
    assign inst      = out_q.inst;
    assign brk       = done_q & out_q.brk;
    assign ivd       = done_q & out_q.ivd;
    assign gpr_wen   = done_q & out_q.gpr_wen & (out_q.gpr_waddr != '0);
    assign gpr_waddr = out_q.gpr_waddr;
    assign gpr_wdata = out_q.gpr_wdata;
    assign csr_wen   = done_q & out_q.csr_wen;
    assign csr_waddr = out_q.csr_waddr;
    assign csr_wdata = out_q.csr_wdata;
    assign halted    = (state_q == HALTED);

`ifdef DBG_COMMIT_CNT_EN
    logic [63:0] instret_q, cycles_q;

    // Retired-instruction and run-time counters; cycles freeze once halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (done_q)            instret_q <= instret_q + 64'd1;
            if (state_q != HALTED) cycles_q  <= cycles_q + 64'd1;
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`endif

endmodule
